// File: rtl/hpu_pkg.sv
// hpu_pkg: state encodings, config select codes and reset defaults for phase_seq.
package hpu_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  localparam logic [1:0] SEL_ITEM   = 2'd0;
  localparam logic [1:0] SEL_ADDR_I = 2'd1;
  localparam logic [1:0] SEL_ADDR_J = 2'd2;
  localparam int DEF_ITEM_NUM = 1000;
  localparam int DEF_ADDR_I   = 299;
  localparam int DEF_ADDR_J   = 2;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating cycle counter with synchronous clear and enable.
module phase_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/phase_seq.sv
// phase_seq: job sequencer stepping IDLE -> GEN (item-memory fill) -> RUN (stream) -> DONE.
module phase_seq
  import hpu_pkg::*;
#(
  parameter int ITEM_W = 16,
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_data,
  input  logic              start,
  input  logic              abort,
  input  logic              last_beat,
  output logic              gen,
  output logic              run,
  output logic [ITEM_W-1:0] item_a,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycles,
  output logic [1:0]        state
);
  state_t r_state, w_next;
  logic [ITEM_W-1:0] r_item_num, r_item_a;
  logic [ADDR_W-1:0] r_addr_i, r_addr_j;
  logic w_go, w_gen_last, w_cfg_ok;
  assign w_go       = (r_state == ST_IDLE || r_state == ST_DONE) && start && !abort;
  assign w_gen_last = r_item_a == r_item_num - ITEM_W'(1);
  assign w_cfg_ok   = cfg_we && !busy;
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (abort) w_next = ST_IDLE;
    else if (w_go) w_next = (r_item_num == '0) ? ST_RUN : ST_GEN;
    else if (r_state == ST_GEN && w_gen_last) w_next = ST_RUN;
    else if (r_state == ST_RUN && last_beat) w_next = ST_DONE;
  end
  always_comb begin
    gen   = r_state == ST_GEN;
    run   = r_state == ST_RUN;
    busy  = r_state == ST_GEN || r_state == ST_RUN;
    done  = r_state == ST_DONE;
    state = r_state;
  end
  // item_a parks on the last index so it reads item_num-1 after GEN, and freezes on abort
  always_ff @(posedge clk) begin
    if (rst) begin
      r_item_a   <= '0;
      r_item_num <= ITEM_W'(DEF_ITEM_NUM);
      r_addr_i   <= ADDR_W'(DEF_ADDR_I);
      r_addr_j   <= ADDR_W'(DEF_ADDR_J);
    end else begin
      if (w_go) r_item_a <= '0;
      else if (r_state == ST_GEN && !w_gen_last && !abort) r_item_a <= r_item_a + 1'b1;
      r_item_num <= (w_cfg_ok && cfg_sel == SEL_ITEM)   ? ITEM_W'(cfg_data) : r_item_num;
      r_addr_i   <= (w_cfg_ok && cfg_sel == SEL_ADDR_I) ? ADDR_W'(cfg_data) : r_addr_i;
      r_addr_j   <= (w_cfg_ok && cfg_sel == SEL_ADDR_J) ? ADDR_W'(cfg_data) : r_addr_j;
    end
  end
  assign item_a = r_item_a;
  assign addr_i = r_addr_i;
  assign addr_j = r_addr_j;
  phase_timer #(.W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_go),
    .en   (busy && !abort),
    .count(cycles)
  );
endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: directed vector table plus hand-written default-job, reset and abort sequences.
module tb_phase_seq;
  logic        clk = 0;
  logic        rst = 0, cfg_we = 0, start = 0, abort = 0, last_beat = 0;
  logic [1:0]  cfg_sel = 0;
  logic [31:0] cfg_data = 0;
  logic        gen, run, busy, done;
  logic [15:0] item_a;
  logic [19:0] addr_i, addr_j;
  logic [31:0] cycles;
  logic [1:0]  state;
  int n_err = 0, n_chk = 0;

  always #5 clk = ~clk;

  phase_seq dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .start(start), .abort(abort), .last_beat(last_beat), .gen(gen), .run(run),
    .item_a(item_a), .addr_i(addr_i), .addr_j(addr_j), .busy(busy), .done(done),
    .cycles(cycles), .state(state)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        st, ab, lb;
    logic [1:0]  e_state;
    logic [15:0] e_item;
    logic [31:0] e_cyc;
    logic [19:0] e_ai, e_aj;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic v(input logic we, input logic [1:0] sel, input logic [31:0] data,
                   input logic st, input logic ab, input logic lb, input logic [1:0] es,
                   input logic [15:0] ei, input logic [31:0] ec, input logic [19:0] eai,
                   input logic [19:0] eaj);
    vec_t x;
    x.we = we; x.sel = sel; x.data = data; x.st = st; x.ab = ab; x.lb = lb;
    x.e_state = es; x.e_item = ei; x.e_cyc = ec; x.e_ai = eai; x.e_aj = eaj;
    vq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cfg_we = 0; start = 0; abort = 0; last_beat = 0;
    step();
    rst = 0;
  endtask

  task automatic gen_run(input int poke, output int gens, output int bad, output logic run_after);
    gens = 0; bad = 0; run_after = 0;
    start = 1;
    step();
    start = 0;
    for (int c = 0; c < 1100; c++) begin
      if (!gen) begin
        run_after = run;
        break;
      end
      if (item_a !== gens[15:0]) bad++;
      gens++;
      start = (gens == poke);
      step();
    end
    start = 0;
  endtask

  initial begin
    int gens, bad, pulses;
    logic ra;
    do_reset();
    chk("rst_state", 32'(state), 0);
    chk("rst_gen_run", {30'd0, gen, run}, 0);
    chk("rst_busy_done", {30'd0, busy, done}, 0);
    chk("rst_item_a", 32'(item_a), 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_addr_i", 32'(addr_i), 299);
    chk("rst_addr_j", 32'(addr_j), 2);

    // reset in the middle of GEN
    start = 1;
    step();
    start = 0;
    for (int c = 0; c < 600 && item_a != 16'd500; c++) step();
    chk("mid_gen_item_a", 32'(item_a), 500);
    chk("mid_gen_gen", 32'(gen), 1);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mid_state", 32'(state), 0);
    chk("rst_mid_item_a", 32'(item_a), 0);
    chk("rst_mid_cycles", cycles, 0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      pulses += int'(gen) + int'(run);
      step();
    end
    chk("rst_mid_no_pulse", 32'(pulses), 0);

    // default job with a stray start while generating
    gen_run(10, gens, bad, ra);
    chk("dflt_gen_len", 32'(gens), 1000);
    chk("dflt_item_seq_bad", 32'(bad), 0);
    chk("dflt_run_after", 32'(ra), 1);
    chk("dflt_item_a_hold", 32'(item_a), 999);
    chk("dflt_cycles", cycles, 1000);
    abort = 1;
    step();
    abort = 0;
    chk("dflt_abort_state", 32'(state), 0);
    chk("dflt_abort_cycles", cycles, 1000);

    do_reset();
    v(1, 0, 4,            0, 0, 0, 0, 0, 0, 299, 2);
    v(0, 0, 0,            1, 0, 0, 1, 0, 0, 299, 2);
    v(1, 0, 100,          0, 0, 0, 1, 1, 1, 299, 2);
    v(0, 0, 0,            0, 0, 1, 1, 2, 2, 299, 2);
    v(0, 0, 0,            0, 0, 0, 1, 3, 3, 299, 2);
    v(0, 0, 0,            0, 0, 0, 2, 3, 4, 299, 2);
    v(1, 1, 7,            1, 0, 0, 2, 3, 5, 299, 2);
    for (int k = 6; k <= 13; k++) v(0, 0, 0, 0, 0, 0, 2, 3, 32'(k), 299, 2);
    v(0, 0, 0,            0, 0, 1, 3, 3, 14, 299, 2);
    v(1, 1, 7,            0, 0, 0, 3, 3, 14, 7, 2);
    v(1, 3, 55,           0, 0, 0, 3, 3, 14, 7, 2);
    v(1, 2, 32'hABC12345, 0, 0, 0, 3, 3, 14, 7, 20'h12345);
    v(0, 0, 0,            1, 0, 0, 1, 0, 0, 7, 20'h12345);
    v(0, 0, 0,            0, 0, 0, 1, 1, 1, 7, 20'h12345);
    v(0, 0, 0,            1, 1, 0, 0, 1, 1, 7, 20'h12345);
    v(0, 0, 0,            1, 0, 0, 1, 0, 0, 7, 20'h12345);
    v(0, 0, 0,            0, 0, 0, 1, 1, 1, 7, 20'h12345);
    v(0, 0, 0,            0, 0, 0, 1, 2, 2, 7, 20'h12345);
    v(0, 0, 0,            0, 0, 0, 1, 3, 3, 7, 20'h12345);
    v(0, 0, 0,            0, 0, 0, 2, 3, 4, 7, 20'h12345);
    v(0, 0, 0,            0, 1, 1, 0, 3, 4, 7, 20'h12345);
    v(1, 0, 0,            0, 0, 0, 0, 3, 4, 7, 20'h12345);
    v(0, 0, 0,            1, 0, 0, 2, 0, 0, 7, 20'h12345);
    v(0, 0, 0,            0, 0, 0, 2, 0, 1, 7, 20'h12345);
    v(0, 0, 0,            0, 0, 1, 3, 0, 2, 7, 20'h12345);
    v(0, 0, 0,            0, 1, 0, 0, 0, 2, 7, 20'h12345);
    foreach (vq[i]) begin
      cfg_we = vq[i].we; cfg_sel = vq[i].sel; cfg_data = vq[i].data;
      start = vq[i].st; abort = vq[i].ab; last_beat = vq[i].lb;
      step();
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vq[i].e_state));
      chk($sformatf("v%0d_item_a", i), 32'(item_a), 32'(vq[i].e_item));
      chk($sformatf("v%0d_cycles", i), cycles, vq[i].e_cyc);
      chk($sformatf("v%0d_addr_i", i), 32'(addr_i), 32'(vq[i].e_ai));
      chk($sformatf("v%0d_addr_j", i), 32'(addr_j), 32'(vq[i].e_aj));
      chk($sformatf("v%0d_flags", i), {28'd0, gen, run, busy, done},
          {28'd0, vq[i].e_state == 2'd1, vq[i].e_state == 2'd2,
           vq[i].e_state == 2'd1 || vq[i].e_state == 2'd2, vq[i].e_state == 2'd3});
    end
    cfg_we = 0; start = 0; abort = 0; last_beat = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
